// File: rtl/dual_edge_deser_pkg.sv
// -----------------------------------------------------------------------------
// dual_edge_pkg
//   Shared definitions for the dual-edge deserialiser slice:
//     mode_e     capture mode encodings (11 is reserved and treated as DDR)
//     cnt_width  width of the beat counter for a given packing ratio
// -----------------------------------------------------------------------------
package dual_edge_pkg;

  typedef enum logic [1:0] {
    SDR_RISE = 2'b00,
    SDR_FALL = 2'b01,
    DDR      = 2'b10,
    DDR_RSVD = 2'b11
  } mode_e;

  // The counter must represent 0..ratio inclusive.
  function automatic int cnt_width(input int ratio);
    return $clog2(ratio + 1);
  endfunction

endpackage

// File: rtl/dual_edge_deser_if.sv
// -----------------------------------------------------------------------------
// dual_edge_deser_if
//   Bundles the data/control signals of dual_edge_deser.
//   master : drives en, mode, flush, d; observes q and the packed-word outputs
//   slave  : the deserialiser itself
//   Signals:
//     en           beat enable, sampled on every capturing edge
//     mode         capture mode (see dual_edge_pkg::mode_e)
//     flush        emit a partial word (posedge-sampled)
//     d            W-bit input data
//     q            last captured sample (dual-edge mirror)
//     word_out     RATIO packed beats, oldest beat in the low bits
//     word_valid   one-cycle pulse per emitted word
//     word_partial qualifies word_valid: word was flushed short
//     beat_cnt     beats currently held in the packer
// -----------------------------------------------------------------------------
interface dual_edge_deser_if #(
  parameter int W     = 4,
  parameter int RATIO = 4
);
  import dual_edge_pkg::*;

  logic                            en;
  logic [1:0]                      mode;
  logic                            flush;
  logic [W-1:0]                    d;
  logic [W-1:0]                    q;
  logic [W*RATIO-1:0]              word_out;
  logic                            word_valid;
  logic                            word_partial;
  logic [cnt_width(RATIO)-1:0]     beat_cnt;

  modport master (
    output en, mode, flush, d,
    input  q, word_out, word_valid, word_partial, beat_cnt
  );

  modport slave (
    input  en, mode, flush, d,
    output q, word_out, word_valid, word_partial, beat_cnt
  );

endinterface

// File: rtl/dual_edge_sampler.sv
// -----------------------------------------------------------------------------
// dual_edge_sampler
//   Captures d on both clock edges and mirrors the latest sample onto q.
//   Ports:
//     clk      clock; posedge fills rise_reg, negedge fills fall_reg/n_en
//     rst      synchronous active-high reset, honoured on each edge for the
//              registers clocked by that edge
//     en       beat enable, registered on negedge into n_en
//     mode     selects which captured sample q shows
//     d        input data
//     fall_reg sample taken at the last negedge
//     n_en     en as seen at the last negedge
//     q        rise_reg / fall_reg / clk-phase mux depending on mode
// -----------------------------------------------------------------------------
module dual_edge_sampler
  import dual_edge_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  mode_e        mode,
  input  logic [W-1:0] d,
  output logic [W-1:0] fall_reg,
  output logic         n_en,
  output logic [W-1:0] q
);

  logic [W-1:0] rise_reg;

  // NOTE: state elements use non-blocking assignment so every flop samples
  // pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk) begin
    if (rst) rise_reg <= '0;
    else     rise_reg <= d;
  end

  always_ff @(negedge clk) begin
    if (rst) begin
      fall_reg <= '0;
      n_en     <= 1'b0;
    end else begin
      fall_reg <= d;
      n_en     <= en;
    end
  end

  // In DDR the clock level picks whichever edge captured most recently:
  // high phase follows the posedge sample, low phase the negedge sample.
  always_comb begin
    // NOTE: a default assignment up front keeps every path assigned, so no
    // latch is inferred if a case arm is ever left incomplete.
    q = rise_reg;
    case (mode)
      SDR_RISE: q = rise_reg;
      SDR_FALL: q = fall_reg;
      default:  q = clk ? rise_reg : fall_reg;
    endcase
  end

endmodule

// File: rtl/dual_edge_deser.sv
// -----------------------------------------------------------------------------
// dual_edge_deser
//   Dual-edge capture front end plus a posedge beat packer. Up to two beats
//   arrive per posedge (DDR: negedge beat then posedge beat); every RATIO
//   beats form one word_out with a word_valid pulse. A spare beat from an
//   overfull cycle is carried into the next word. flush emits a short,
//   zero-padded word; a mode change discards the word in progress.
//   Ports:
//     clk  clock (both edges capture, posedge packs)
//     rst  synchronous active-high reset
//     bus  dual_edge_deser_if.slave (en, mode, flush, d, q, word_out,
//          word_valid, word_partial, beat_cnt)
// -----------------------------------------------------------------------------
module dual_edge_deser
  import dual_edge_pkg::*;
#(
  parameter int W     = 4,
  parameter int RATIO = 4
) (
  input logic              clk,
  input logic              rst,
  dual_edge_deser_if.slave bus
);

  localparam int CW = cnt_width(RATIO);

  typedef logic [W-1:0] beat_t;

  mode_e        mode_in;
  mode_e        mode_q;
  beat_t        fall_reg;
  logic         n_en;

  assign mode_in = mode_e'(bus.mode);

  dual_edge_sampler #(.W(W)) u_sampler (
    .clk      (clk),
    .rst      (rst),
    .en       (bus.en),
    .mode     (mode_in),
    .d        (bus.d),
    .fall_reg (fall_reg),
    .n_en     (n_en),
    .q        (bus.q)
  );

  // ---------------------------------------------------------------------------
  // Beats arriving at this posedge. b0 is always the older one.
  // ---------------------------------------------------------------------------
  logic [1:0] nb;
  beat_t      b0;
  beat_t      b1;

  always_comb begin
    nb = 2'd0;
    b0 = bus.d;
    b1 = bus.d;
    case (mode_in)
      SDR_RISE: nb = {1'b0, bus.en};
      SDR_FALL: begin
        nb = {1'b0, n_en};
        b0 = fall_reg;
      end
      default: begin
        if (n_en) begin
          b0 = fall_reg;
          nb = bus.en ? 2'd2 : 2'd1;
        end else begin
          nb = {1'b0, bus.en};
        end
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Packer: held beats followed by the new ones, zero beyond the total so a
  // flushed word comes out padded without a separate mask.
  // ---------------------------------------------------------------------------
  beat_t               hold        [RATIO+1];
  beat_t               comb_beats  [RATIO+1];
  logic [CW-1:0]       cnt_q;
  logic [CW:0]         total;
  logic                full;
  logic [W*RATIO-1:0]  word_next;

  always_comb begin
    total = {1'b0, cnt_q} + {{(CW-1){1'b0}}, nb};
    full  = (total >= (CW+1)'(RATIO));
    for (int i = 0; i <= RATIO; i++) begin
      comb_beats[i] = '0;
      if (i < int'(cnt_q))
        comb_beats[i] = hold[i];
      else if (i == int'(cnt_q) && nb != 2'd0)
        comb_beats[i] = b0;
      else if (i == int'(cnt_q) + 1 && nb == 2'd2)
        comb_beats[i] = b1;
    end
    for (int i = 0; i < RATIO; i++)
      word_next[i*W +: W] = comb_beats[i];
  end

  // NOTE: the beat store has no reset; cnt_q marks which entries are live
  // and stale slots never reach word_out because comb_beats zeroes them.
  always_ff @(posedge clk) begin
    for (int i = 0; i <= RATIO; i++) begin
      if (full) hold[i] <= (i == 0) ? comb_beats[RATIO] : '0;
      else      hold[i] <= comb_beats[i];
    end
  end

  logic [W*RATIO-1:0] word_q;
  logic               valid_q;
  logic               partial_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      valid_q   <= 1'b0;
      partial_q <= 1'b0;
      word_q    <= '0;
      mode_q    <= SDR_RISE;
    end else begin
      mode_q    <= mode_in;
      valid_q   <= 1'b0;
      partial_q <= 1'b0;
      if (mode_in != mode_q) begin
        // Beats captured under the old mode are meaningless in the new one.
        cnt_q <= '0;
      end else if (full) begin
        word_q  <= word_next;
        valid_q <= 1'b1;
        cnt_q   <= CW'(total - (CW+1)'(RATIO));
      end else if (bus.flush && total != '0) begin
        word_q    <= word_next;
        valid_q   <= 1'b1;
        partial_q <= 1'b1;
        cnt_q     <= '0;
      end else begin
        cnt_q <= CW'(total);
      end
    end
  end

  assign bus.word_out     = word_q;
  assign bus.word_valid   = valid_q;
  assign bus.word_partial = partial_q;
  assign bus.beat_cnt     = cnt_q;

endmodule

// File: doc/dual_edge_deser.md
Name: dual_edge_deser

Overview:
Parameterised dual-edge capture block that samples a W-bit input on rising and/or falling clk edges and packs RATIO consecutive beats into one wide word with a valid pulse. It succeeds the simple dual-edge flop, adding mode select, enable gating, a beat packer with carry-over, and flush. It sits at DDR-style input pins, ahead of single-edge (posedge) consumer logic.

Parameters:
W, 4, data bits per beat (>=1)
RATIO, 4, beats packed per output word (>=2)

Ports:
clk  in  1  clock; both edges used for capture, posedge for all packing logic
rst  in  1  reset, synchronous, active-high; sampled on posedge for posedge state, on negedge for negedge state
en  in  1  beat enable; sampled on each capturing edge
mode  in  2  00 SDR_RISE, 01 SDR_FALL, 10 DDR, 11 reserved (behaves as DDR)
flush  in  1  emit partial word (posedge-sampled)
d  in  W  input data
q  out  W  last captured sample (dual-edge mirror)
word_out  out  W*RATIO  packed word; beat 0 (oldest) in bits [W-1:0]
word_valid  out  1  one posedge-cycle pulse per emitted word
word_partial  out  1  qualifies word_valid: 1 = flushed short word
beat_cnt  out  $clog2(RATIO+1)  beats currently held in packer

Behaviour:
- Capture: rise_reg<=d at every posedge; fall_reg<=d and n_en<=en at every negedge; both capture regardless of en; rst clears rise_reg/fall_reg/n_en to 0 on its respective edge.
- q: DDR -> clk ? rise_reg : fall_reg; SDR_RISE -> rise_reg; SDR_FALL -> fall_reg.
- Beats per posedge: SDR_RISE: en (rise sample d). SDR_FALL: n_en (fall_reg). DDR: fall_reg if n_en, then d if en; fall beat is older. Range 0-2.
- Packer: shift register of RATIO+1 beats plus beat_cnt. New beats are appended in time order after held beats.
- If beat_cnt+beats >= RATIO: word_out <= first RATIO beats; word_valid=1; word_partial=0; remaining beat (0 or 1) carried; beat_cnt <= remainder.
- Else: beat_cnt <= beat_cnt+beats; word_valid=0.
- Flush: when flush=1 and 0 < beat_cnt+beats < RATIO, emit held plus incoming beats zero-padded in the upper bits; word_valid=1; word_partial=1; beat_cnt <= 0.
- Flush is ignored when the total is 0 (no pulse) or >= RATIO (normal full emit, carry retained).
- Mode change: mode registered at posedge. A posedge where mode differs from the registered value discards held beats and this cycle's beats; beat_cnt <= 0; no pulse. Packing resumes next posedge.
- word_out/word_valid/word_partial are registered at posedge. word_out holds its last value when word_valid=0.
- Reset: at posedge with rst=1, beat_cnt=0, word_valid=0, word_partial=0, word_out=0, mode register=00. Held beats are discarded mid-word. rst dominates flush and en.
- Latency: word visible after the posedge that completes the RATIO-th beat.

Decomposition:
- Package dual_edge_pkg holds the mode encodings (SDR_RISE, SDR_FALL, DDR) and the beat_cnt width function.
- Sub-module dual_edge_sampler holds rise_reg, fall_reg, n_en and the q mux.
- The packer FSM/counter stays in the top module.

Test Plan:
1. rst=1 for 2 cycles -> q=0, word_valid=0, word_partial=0, beat_cnt=0, word_out=0.
2. DDR, W=4, RATIO=4, en rises before posedge k0. Drive rise/fall/rise/fall/rise = 1,2,3,4,5. Beats per posedge: k0=1 (rise only, n_en=0), k1=2, k2=2. At k2: word_out=0x4321, word_valid=1, beat_cnt=1 (0x5 carried).
3. SDR_RISE, en=1, rise d=A,B,C,D -> word_out=0xDCBA, pulse after 4th posedge. Falling-edge values must not appear in word_out or q.
4. SDR_RISE, beats A,B held, flush=1 with en=0 -> word_out=0x00BA, word_valid=1, word_partial=1, beat_cnt=0. A second flush gives no pulse.
5. Three beats held, mode 00->10 at a posedge -> no pulse, beat_cnt=0. The next 4 beats form a fresh word.
6. beat_cnt=3 mid-word, rst=1 for one posedge -> beat_cnt=0, word_valid=0. fall_reg=0 after the following negedge. Resume gives a clean first word.
